// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared encodings for the data-memory load/store initiator:
//     - memory Mode encodings (MODE_*), which match the request size field
//     - request size encodings (SIZE_*)
//     - FSM state encodings (ST_*)
//     - access_error(): the alignment / legal-size check
// ---------------------------------------------------------------------------
package mem_pkg;

    // Memory Mode port encodings
    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

    // Request size encodings. These deliberately equal the memory modes, so a
    // store's size can be passed straight through to the memory Mode port.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    // FSM states
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ACCESS  = 2'b01;
    localparam logic [1:0] ST_CAPTURE = 2'b10;
    localparam logic [1:0] ST_RESP    = 2'b11;

    // Returns 1 for a misaligned access or an illegal size.
    function automatic logic access_error(input logic [1:0] size,
                                          input logic [1:0] addr_lsb);
        logic err;
        err = 1'b0;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = addr_lsb[0];
            SIZE_WORD: err = (addr_lsb != 2'b00);
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
//   Combinational load extraction: picks the byte or halfword lane out of a
//   full memory word and sign- or zero-extends it to 32 bits.
// Ports
//   i_word      in  32  full word read from memory
//   i_addr_lsb  in  2   byte address bits [1:0]
//   i_size      in  2   SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   i_unsigned  in  1   1 = zero-extend, 0 = sign-extend (ignored for words)
//   o_data      out 32  extended load result
// ---------------------------------------------------------------------------
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lsb,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case statements can leave it unassigned (latch).
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = i_word;

        case (i_addr_lsb)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase

        w_half = i_addr_lsb[1] ? i_word[31:16] : i_word[15:0];

        case (i_size)
            SIZE_BYTE: o_data = i_unsigned ? {24'h0, w_byte}
                                           : {{24{w_byte[7]}}, w_byte};
            SIZE_HALF: o_data = i_unsigned ? {16'h0, w_half}
                                           : {{16{w_half[15]}}, w_half};
            default:   o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store initiator between the MEM pipeline stage and the data memory.
//   Accepts one request at a time. Loads always read a full word and extract
//   the lane locally; stores hand the lane placement to the memory via Mode.
//   Misaligned or illegal-size requests are answered with rsp_err and never
//   touch the memory.
//   Latency from accept edge to rsp_valid: load 3, store 2, error 1 cycles.
// Ports
//   clk, clr_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_we/size/unsigned/addr/wdata   request fields, registered on accept
//   rsp_valid/rsp_rdata/rsp_err       one-cycle response
//   mem_addr/din/mode/str/sel/ld      memory port
//   mem_dout                   memory read data
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic [1:0]            mem_mode,
    output logic                  mem_str,
    output logic                  mem_sel,
    output logic                  mem_ld,
    input  logic [31:0]           mem_dout
);

    logic [1:0]            r_state;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_err;

    logic [1:0]  w_next_state;
    logic        w_accept;
    logic        w_req_err;
    logic        w_active;
    logic        w_store_access;
    logic [31:0] w_load_data;

    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign w_req_err = access_error(req_size, req_addr[1:0]);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS:  w_next_state = r_we ? ST_RESP : ST_CAPTURE;
            ST_CAPTURE: w_next_state = ST_RESP;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    load_align u_load_align (
        .i_word     (mem_dout),
        .i_addr_lsb (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_size     <= SIZE_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            r_state <= w_next_state;
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_err      <= w_req_err;
                // Stores and errors respond with zero data.
                r_rdata    <= 32'h0;
            end
            if (r_state == ST_CAPTURE) begin
                r_rdata <= w_load_data;
            end
        end
    end

    // Memory port is decoded from state rather than registered, so an
    // asynchronous reset during ACCESS drops mem_str/mem_sel immediately and
    // the pending write never reaches the memory.
    assign w_active       = (r_state == ST_ACCESS) || (r_state == ST_CAPTURE);
    assign w_store_access = (r_state == ST_ACCESS) && r_we;

    assign mem_sel  = w_active;
    assign mem_str  = w_store_access;
    assign mem_ld   = 1'b1;
    assign mem_addr = w_active ? r_addr : '0;
    assign mem_din  = w_store_access ? r_wdata : 32'h0;
    // Loads always read a whole word; only stores use the memory's lane logic.
    assign mem_mode = w_active ? (r_we ? r_size : MODE_WORD) : MODE_BYTE;

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = (r_state == ST_RESP) && r_err;
    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a small behavioural data memory
//   (8 words, byte/half/word store lanes, registered read port).
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        clr_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  mem_addr;
    logic [31:0] mem_din;
    logic [1:0]  mem_mode;
    logic        mem_str;
    logic        mem_sel;
    logic        mem_ld;
    logic [31:0] mem_dout;

    int n_checks;
    int n_fails;
    int sel_count;
    int load_mode_bad;

    logic [31:0] mem [8];

    mem_access_unit #(.ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_mode     (mem_mode),
        .mem_str      (mem_str),
        .mem_sel      (mem_sel),
        .mem_ld       (mem_ld),
        .mem_dout     (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: lane placement on store, registered read.
    always @(posedge clk) begin
        if (mem_sel && mem_str) begin
            case (mem_mode)
                2'b00:   mem[mem_addr[4:2]][8*mem_addr[1:0] +: 8] <= mem_din[7:0];
                2'b01:   mem[mem_addr[4:2]][16*mem_addr[1] +: 16] <= mem_din[15:0];
                default: mem[mem_addr[4:2]] <= mem_din;
            endcase
        end
        if (mem_sel && mem_ld) begin
            mem_dout <= mem[mem_addr[4:2]];
        end
    end

    always @(posedge clk) begin
        if (mem_sel) sel_count <= sel_count + 1;
        if (mem_sel && !mem_str && mem_mode != 2'b10) load_mode_bad <= load_mode_bad + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request when idle; returns response data, error flag and the
    // number of edges from the accept edge to rsp_valid (10 = timed out).
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [4:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          sel_before;
        int          n_acc;
        int          n_rsp;
        int          acc_cyc [3];
        int          cyc;
        logic        acc_now;
        logic [4:0]  b2b_addr [3];
        logic [31:0] b2b_exp [3];

        n_checks      = 0;
        n_fails       = 0;
        sel_count     = 0;
        load_mode_bad = 0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h1111_1111 * i;
        mem[1]   = 32'h8765_43A1;
        mem_dout = 32'h0;

        vecs[0]  = '{"LB 0x4",     1'b0, 2'b00, 1'b0, 5'h04, 32'h0,      32'hFFFF_FFA1, 1'b0, 3};
        vecs[1]  = '{"LBU 0x4",    1'b0, 2'b00, 1'b1, 5'h04, 32'h0,      32'h0000_00A1, 1'b0, 3};
        vecs[2]  = '{"LB 0x5",     1'b0, 2'b00, 1'b0, 5'h05, 32'h0,      32'h0000_0043, 1'b0, 3};
        vecs[3]  = '{"LH 0x6",     1'b0, 2'b01, 1'b0, 5'h06, 32'h0,      32'hFFFF_8765, 1'b0, 3};
        vecs[4]  = '{"LHU 0x6",    1'b0, 2'b01, 1'b1, 5'h06, 32'h0,      32'h0000_8765, 1'b0, 3};
        vecs[5]  = '{"LW 0x4",     1'b0, 2'b10, 1'b0, 5'h04, 32'h0,      32'h8765_43A1, 1'b0, 3};
        vecs[6]  = '{"SB 0x7",     1'b1, 2'b00, 1'b0, 5'h07, 32'h55,     32'h0,         1'b0, 2};
        vecs[7]  = '{"LW after SB",1'b0, 2'b10, 1'b0, 5'h04, 32'h0,      32'h5565_43A1, 1'b0, 3};
        vecs[8]  = '{"SH 0x4",     1'b1, 2'b01, 1'b0, 5'h04, 32'hBEEF,   32'h0,         1'b0, 2};
        vecs[9]  = '{"LW after SH",1'b0, 2'b10, 1'b0, 5'h04, 32'h0,      32'h5565_BEEF, 1'b0, 3};
        vecs[10] = '{"SH 0x3 err", 1'b1, 2'b01, 1'b0, 5'h03, 32'h1234,   32'h0,         1'b1, 1};
        vecs[11] = '{"LW 0x6 err", 1'b0, 2'b10, 1'b0, 5'h06, 32'h0,      32'h0,         1'b1, 1};
        vecs[12] = '{"size11 err", 1'b1, 2'b11, 1'b0, 5'h04, 32'hFFFF_FFFF, 32'h0,      1'b1, 1};
        vecs[13] = '{"LW after err",1'b0,2'b10, 1'b0, 5'h04, 32'h0,      32'h5565_BEEF, 1'b0, 3};
        vecs[14] = '{"LB 0x7",     1'b0, 2'b00, 1'b0, 5'h07, 32'h0,      32'h0000_0055, 1'b0, 3};
        vecs[15] = '{"LH 0x4",     1'b0, 2'b01, 1'b0, 5'h04, 32'h0,      32'hFFFF_BEEF, 1'b0, 3};
        vecs[16] = '{"LW uns 0x4", 1'b0, 2'b10, 1'b1, 5'h04, 32'h0,      32'h5565_BEEF, 1'b0, 3};

        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 5'h0;
        req_wdata    = 32'h0;
        clr_n        = 1'b0;
        #1;

        // Reset state
        check("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst rsp_err",   {31'h0, rsp_err},   32'h0);
        check("rst rsp_rdata", rsp_rdata,          32'h0);
        check("rst mem_sel",   {31'h0, mem_sel},   32'h0);
        check("rst mem_str",   {31'h0, mem_str},   32'h0);
        check("rst mem_addr",  {27'h0, mem_addr},  32'h0);
        check("rst mem_din",   mem_din,            32'h0);
        check("rst mem_mode",  {30'h0, mem_mode},  32'h0);
        check("rst mem_ld",    {31'h0, mem_ld},    32'h1);
        check("rst req_ready", {31'h0, req_ready}, 32'h1);

        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        // Table-driven single requests
        for (int i = 0; i < 17; i++) begin
            sel_before = sel_count;
            run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check({vecs[i].name, " rdata"},   rd,                  vecs[i].exp_rdata);
            check({vecs[i].name, " err"},     {31'h0, er},         {31'h0, vecs[i].exp_err});
            check({vecs[i].name, " latency"}, lat,                 vecs[i].exp_lat);
            check({vecs[i].name, " mem_sel seen"},
                  {31'h0, sel_count != sel_before}, {31'h0, !vecs[i].exp_err});
        end
        check("word1 after table", mem[1], 32'h5565_BEEF);

        // req_valid held high across three loads
        b2b_addr[0] = 5'h04; b2b_exp[0] = 32'h0000_00EF;
        b2b_addr[1] = 5'h05; b2b_exp[1] = 32'h0000_00BE;
        b2b_addr[2] = 5'h06; b2b_exp[2] = 32'h0000_0065;
        n_acc = 0;
        n_rsp = 0;
        @(negedge clk);
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b1;
        req_addr     = b2b_addr[0];
        req_valid    = 1'b1;
        for (cyc = 0; cyc < 40 && n_rsp < 3; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                check($sformatf("b2b rdata %0d", n_rsp), rsp_rdata, b2b_exp[n_rsp]);
                n_rsp++;
            end
            acc_now = req_valid && req_ready;
            @(posedge clk);
            if (acc_now) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            #1;
            if (n_acc < 3) req_addr = b2b_addr[n_acc];
            else           req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("b2b accepts",   n_acc, 3);
        check("b2b responses", n_rsp, 3);
        if (n_acc == 3) begin
            check("b2b spacing 0-1", acc_cyc[1] - acc_cyc[0], 4);
            check("b2b spacing 1-2", acc_cyc[2] - acc_cyc[1], 4);
        end

        // Reset during ACCESS of a store: the write must not happen
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 5'h04;
        req_wdata = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("store access mem_str", {31'h0, mem_str}, 32'h1);
        clr_n = 1'b0;
        #1;
        check("midrst mem_str",   {31'h0, mem_str},   32'h0);
        check("midrst mem_sel",   {31'h0, mem_sel},   32'h0);
        check("midrst mem_din",   mem_din,            32'h0);
        check("midrst mem_addr",  {27'h0, mem_addr},  32'h0);
        check("midrst mem_mode",  {30'h0, mem_mode},  32'h0);
        check("midrst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("midrst req_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        clr_n = 1'b1;
        begin
            int rv_seen;
            rv_seen = 0;
            repeat (4) begin
                @(negedge clk);
                if (rsp_valid) rv_seen++;
            end
            check("midrst no response", rv_seen, 0);
        end
        check("midrst word1 memory", mem[1], 32'h5565_BEEF);
        run_req(1'b0, 2'b10, 1'b0, 5'h04, 32'h0, rd, er, lat);
        check("midrst LW 0x4", rd, 32'h5565_BEEF);

        check("loads used word mode", load_mode_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
